// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   size_e      : d_size encodings (byte / half / word / reserved)
//   arb_state_e : arbiter FSM states
//   streak_t    : width of the consecutive-data-grant counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        RMW_WR = 1'b1
    } arb_state_e;

    localparam int unsigned STREAK_W = 4;
    typedef logic [STREAK_W-1:0] streak_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: instruction-fetch port and
// load/store port.
//   master : the pipeline model (drives requests, receives grants/responses)
//   slave  : the arbiter
interface mem_arbiter_if;

    // Fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    // Load/store port
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err
    );

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err
    );

endinterface

// File: rtl/mem_arbiter_store_merge.sv
// Combinational lane merge for sub-word stores plus alignment check.
//   old_word_i   : current memory word
//   wdata_i      : right-aligned store data
//   size_i       : access size
//   addr_lo_i    : byte address bits [1:0]
//   merged_o     : old word with the addressed lane replaced (wdata for word)
//   misaligned_o : misaligned half/word, or reserved size
module store_merge
    import mem_arb_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] merged_o,
    output logic        misaligned_o
);

    always_comb begin
        merged_o     = old_word_i;
        misaligned_o = 1'b0;
        unique case (size_i)
            SZ_BYTE: begin
                unique case (addr_lo_i)
                    2'd0: merged_o[7:0]   = wdata_i[7:0];
                    2'd1: merged_o[15:8]  = wdata_i[7:0];
                    2'd2: merged_o[23:16] = wdata_i[7:0];
                    2'd3: merged_o[31:24] = wdata_i[7:0];
                    default: merged_o     = old_word_i;
                endcase
            end
            SZ_HALF: begin
                misaligned_o = addr_lo_i[0];
                if (addr_lo_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_WORD: begin
                misaligned_o = (addr_lo_i != 2'd0);
                merged_o     = wdata_i;
            end
            default: misaligned_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port word memory between instruction fetch
// and load/store. Data wins each cycle, but after MAX_DATA_STREAK data
// grants with fetch waiting, fetch is forced through. Byte/half stores are
// a read-modify-write: read+merge in ARB, write back in RMW_WR.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : requester bus (slave side)
//   mem_we     : memory write enable
//   mem_addr   : memory byte address (word index = [31:2])
//   mem_wdata  : memory write data
//   mem_rdata  : combinational memory read data for mem_addr
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned WORD            = 32
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata
);

    localparam streak_t STREAK_MAX = streak_t'(MAX_DATA_STREAK);

    arb_state_e      state_q;
    streak_t         streak_q, streak_d;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] merged_q;
    logic            if_rvalid_q, d_rvalid_q, d_err_q;
    logic [WORD-1:0] if_rdata_q, d_rdata_q;

    logic            if_gnt, d_gnt, fetch_forced;
    logic [WORD-1:0] merged;
    logic            misaligned;
    size_e           dsize;

    assign dsize = size_e'(bus.d_size);

    store_merge u_merge (
        .old_word_i   (mem_rdata),
        .wdata_i      (bus.d_wdata),
        .size_i       (dsize),
        .addr_lo_i    (bus.d_addr[1:0]),
        .merged_o     (merged),
        .misaligned_o (misaligned)
    );

    always_comb begin
        fetch_forced = bus.if_req && (streak_q == STREAK_MAX);
        d_gnt        = 1'b0;
        if_gnt       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = bus.if_addr;
        mem_wdata    = bus.d_wdata;
        streak_d     = streak_q;
        if (!rst) begin
            if (state_q == ARB) begin
                d_gnt  = bus.d_req && !fetch_forced;
                if_gnt = bus.if_req && !d_gnt;
                if (d_gnt) begin
                    mem_addr = bus.d_addr;
                    // only aligned full-word stores write directly
                    mem_we   = bus.d_we && !misaligned && (dsize == SZ_WORD);
                end
                if (!bus.if_req || if_gnt) begin
                    streak_d = '0;
                end else if (d_gnt && (streak_q != STREAK_MAX)) begin
                    streak_d = streak_q + 1'b1;
                end
            end else begin
                mem_we    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merged_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            streak_q    <= '0;
            addr_q      <= '0;
            merged_q    <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            unique case (state_q)
                ARB: begin
                    streak_q <= streak_d;
                    if (if_gnt) begin
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= mem_rdata;
                    end
                    if (d_gnt) begin
                        if (misaligned) begin
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                            d_rdata_q  <= '0;
                        end else if (!bus.d_we) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= mem_rdata;
                        end else if (dsize == SZ_WORD) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= '0;
                        end else begin
                            addr_q   <= bus.d_addr;
                            merged_q <= merged;
                            state_q  <= RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= '0;
                    state_q    <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned MAXS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dmem    [64];
    logic [31:0] ref_mem [64];

    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

    mem_arbiter #(.MAX_DATA_STREAK(MAXS), .WORD(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t d_q[$];
    resp_t f_q[$];
    resp_t mon_e;

    // reference model state
    int unsigned dgrants_waiting = 0;  // data grants since fetch began waiting
    bit          rmw_cycle       = 0;  // next cycle is the write-back of a sub-word store
    logic [31:0] rmw_addr, rmw_word;
    int unsigned f_wait = 0, f_rmw = 0;
    bit          rst_prev = 1'b1;
    bit          exp_d, exp_i, was_rmw;

    function void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%h want=%h cyc=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic bit misal_ref(logic [1:0] size, logic [31:0] addr);
        return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] merge_ref(logic [31:0] old, logic [31:0] wd,
                                              logic [1:0] size, logic [31:0] addr);
        int unsigned sh;
        logic [31:0] mask;
        if (size == 2'b00) begin
            sh   = 8 * int'(addr[1:0]);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((wd & 32'hFF) << sh);
        end
        sh   = 16 * int'(addr[1]);
        mask = 32'hFFFF << sh;
        return (old & ~mask) | ((wd & 32'hFFFF) << sh);
    endfunction

    // Monitor / scoreboard: responses first, then this cycle's grants.
    always @(negedge clk) begin
        if (rst) begin
            chk(!(bus.if_gnt || bus.d_gnt || mem_we), "rst_outs",
                32'({bus.if_gnt, bus.d_gnt, mem_we}), 32'd0);
            d_q.delete();
            f_q.delete();
            dgrants_waiting = 0;
            rmw_cycle = 0;
            f_wait = 0;
            f_rmw = 0;
            rst_prev = 1'b1;
        end else begin
            if (rst_prev) begin
                chk(!bus.if_rvalid && !bus.d_rvalid && !bus.d_err, "rst_flags",
                    32'({bus.if_rvalid, bus.d_rvalid, bus.d_err}), 32'd0);
                chk(bus.if_rdata == 32'd0 && bus.d_rdata == 32'd0, "rst_rdata",
                    bus.if_rdata | bus.d_rdata, 32'd0);
                rst_prev = 1'b0;
            end

            if (bus.if_rvalid) begin
                if (f_q.size() == 0) chk(1'b0, "if_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = f_q.pop_front();
                    chk(mon_e.due == cyc, "if_latency", cyc, mon_e.due);
                    chk(bus.if_rdata == mon_e.rdata, "if_rdata", bus.if_rdata, mon_e.rdata);
                end
            end else if (f_q.size() != 0 && f_q[0].due <= cyc) begin
                void'(f_q.pop_front());
                chk(1'b0, "if_missing", 32'd0, 32'd1);
            end

            if (bus.d_rvalid) begin
                if (d_q.size() == 0) chk(1'b0, "d_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = d_q.pop_front();
                    chk(mon_e.due == cyc, "d_latency", cyc, mon_e.due);
                    chk(bus.d_rdata == mon_e.rdata, "d_rdata", bus.d_rdata, mon_e.rdata);
                    chk(bus.d_err == mon_e.err, "d_err", 32'(bus.d_err), 32'(mon_e.err));
                end
            end else if (d_q.size() != 0 && d_q[0].due <= cyc) begin
                void'(d_q.pop_front());
                chk(1'b0, "d_missing", 32'd0, 32'd1);
            end

            was_rmw = rmw_cycle;
            if (rmw_cycle) begin
                chk(!bus.if_gnt && !bus.d_gnt, "rmw_nogrant",
                    32'({bus.d_gnt, bus.if_gnt}), 32'd0);
                ref_mem[rmw_addr[7:2]] = rmw_word;
                rmw_cycle = 0;
            end else begin
                exp_d = bus.d_req && !(bus.if_req && dgrants_waiting >= MAXS);
                exp_i = bus.if_req && !exp_d;
                chk(bus.d_gnt == exp_d && bus.if_gnt == exp_i, "grant",
                    32'({bus.d_gnt, bus.if_gnt}), 32'({exp_d, exp_i}));
                if (bus.d_gnt) begin
                    if (misal_ref(bus.d_size, bus.d_addr)) begin
                        d_q.push_back('{cyc + 1, 32'd0, 1'b1});
                    end else if (!bus.d_we) begin
                        d_q.push_back('{cyc + 1, ref_mem[bus.d_addr[7:2]], 1'b0});
                    end else if (bus.d_size == 2'b10) begin
                        ref_mem[bus.d_addr[7:2]] = bus.d_wdata;
                        d_q.push_back('{cyc + 1, 32'd0, 1'b0});
                    end else begin
                        rmw_cycle = 1;
                        rmw_addr  = bus.d_addr;
                        rmw_word  = merge_ref(ref_mem[bus.d_addr[7:2]], bus.d_wdata,
                                              bus.d_size, bus.d_addr);
                        d_q.push_back('{cyc + 2, 32'd0, 1'b0});
                    end
                end
                if (bus.if_gnt) f_q.push_back('{cyc + 1, ref_mem[bus.if_addr[7:2]], 1'b0});
                if (!bus.if_req || bus.if_gnt) dgrants_waiting = 0;
                else if (bus.d_gnt) dgrants_waiting++;
            end

            // fetch starvation bound: MAXS data grants plus any write-back cycles
            if (bus.if_req) begin
                f_wait++;
                if (was_rmw) f_rmw++;
                if (bus.if_gnt) begin
                    chk(f_wait <= MAXS + 1 + f_rmw, "fetch_wait", f_wait, MAXS + 1 + f_rmw);
                    f_wait = 0;
                    f_rmw  = 0;
                end
            end else begin
                f_wait = 0;
                f_rmw  = 0;
            end
        end
    end

    task automatic idle(int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(logic [31:0] addr, logic [31:0] val);
        dmem[addr[7:2]]    = val;
        ref_mem[addr[7:2]] = val;
    endtask

    task automatic data_op(bit we, logic [1:0] size, logic [31:0] addr,
                           logic [31:0] wdata, bit rst_after);
        bit got = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_size  = size;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = bus.d_gnt;
        end
        if (!got) chk(1'b0, "d_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
        if (rst_after) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    task automatic fetch_op(logic [31:0] addr);
        bit got = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = bus.if_gnt;
        end
        if (!got) chk(1'b0, "if_gnt_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
        for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // word store then load
        data_op(1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        data_op(0, 2'b10, 32'h10, 32'h0, 0);

        // byte store read-modify-write
        preload(32'h10, 32'h11223344);
        data_op(1, 2'b00, 32'h11, 32'h000000AA, 0);
        idle(2);
        chk(dmem[4] == 32'h1122AA44, "byte_rmw_mem", dmem[4], 32'h1122AA44);
        data_op(0, 2'b10, 32'h10, 32'h0, 0);

        // misaligned half, reserved size
        data_op(1, 2'b01, 32'h13, 32'h00005555, 0);
        data_op(0, 2'b11, 32'h10, 32'h0, 0);
        idle(2);
        chk(dmem[4] == 32'h1122AA44, "misaligned_nowrite", dmem[4], 32'h1122AA44);

        // aligned upper half store
        data_op(1, 2'b01, 32'h12, 32'h0000BEEF, 0);
        idle(2);
        chk(dmem[4] == 32'hBEEFAA44, "half_rmw_mem", dmem[4], 32'hBEEFAA44);

        // both ports saturated: D,D,D,D,I repeating
        fork
            for (int i = 0; i < 5; i++) fetch_op(32'(i * 4 + 32'h40));
            for (int i = 0; i < 24; i++) data_op(0, 2'b10, 32'(i * 4), 32'h0, 0);
        join
        idle(2);

        // reset during write-back of a byte store aborts it
        preload(32'h20, 32'hCAFEF00D);
        data_op(1, 2'b00, 32'h20, 32'h00000077, 1);
        idle(3);
        chk(dmem[8] == 32'hCAFEF00D, "rst_rmw_nowrite", dmem[8], 32'hCAFEF00D);

        // randomized traffic
        fork
            for (int i = 0; i < 150; i++) begin
                fetch_op(32'($urandom_range(0, 255)));
                if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
            end
            for (int i = 0; i < 250; i++) begin
                logic [1:0]  sz;
                logic [31:0] a;
                sz = 2'($urandom_range(0, 3));
                a  = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 2'b01) a[0] = 1'b0;
                    if (sz == 2'b10) a[1:0] = 2'b00;
                end
                data_op(1'($urandom_range(0, 1)), sz, a, $urandom, 0);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            end
        join
        idle(4);

        begin
            int unsigned diffs = 0;
            for (int i = 0; i < 64; i++) if (dmem[i] !== ref_mem[i]) diffs++;
            chk(diffs == 0, "mem_final", diffs, 32'd0);
        end
        chk(d_q.size() == 0 && f_q.size() == 0, "queues_drained",
            32'(d_q.size() + f_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
